// File: rtl/draw_cmd_arbiter.sv
// draw_cmd_arbiter
//   Two-requester round-robin arbiter that streams draw-command packets
//   (1..4 words) into the DrawUnit command FIFO. A packet is atomic: once a
//   requester is granted, the grant holds until all of its words are written.
//   Every packet is followed by one IDLE cycle in which arbitration happens.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-low
//   req0/req1      packet request per requester
//   len0/len1      packet length in words, sampled at grant (0 means 4)
//   data0/data1    command word per requester
//   valid0/valid1  data word valid per requester
//   ready0/ready1  word accepted when valid & ready
//   full           DrawUnit FIFO full, stalls the transfer
//   we             FIFO write strobe
//   data           FIFO write data (0 while idle)
//   gnt            one-hot current grant, 00 while idle
//   wcount         running count of words written, wraps at 16 bits
module draw_cmd_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  len0,
  input  logic [1:0]  len1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic        valid0,
  input  logic        valid1,
  input  logic        full,
  output logic        ready0,
  output logic        ready1,
  output logic        we,
  output logic [15:0] data,
  output logic [1:0]  gnt,
  output logic [15:0] wcount
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t      state, state_nxt;
  logic        last, last_nxt;   // requester granted most recently
  logic [2:0]  cnt, cnt_nxt;     // words still to be written in this packet

  // 2-bit length code to word count: 0 encodes a 4-word packet
  function automatic logic [2:0] words(input logic [1:0] len);
    words = (len == 2'd0) ? 3'd4 : {1'b0, len};
  endfunction

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    gnt       = 2'b00;
    ready0    = 1'b0;
    ready1    = 1'b0;
    we        = 1'b0;
    data      = 16'd0;
    case (state)
      IDLE: begin
        // on a tie, the requester that did not win last time goes first
        if (req0 && (!req1 || last)) begin
          state_nxt = GRANT0;
          last_nxt  = 1'b0;
          cnt_nxt   = words(len0);
        end else if (req1) begin
          state_nxt = GRANT1;
          last_nxt  = 1'b1;
          cnt_nxt   = words(len1);
        end
      end
      GRANT0: begin
        gnt    = 2'b01;
        ready0 = ~full;
        we     = valid0 & ~full;
        data   = data0;
      end
      GRANT1: begin
        gnt    = 2'b10;
        ready1 = ~full;
        we     = valid1 & ~full;
        data   = data1;
      end
      default: state_nxt = IDLE;
    endcase
    // request lines are ignored while granted; only the word count ends a packet
    if (we) begin
      cnt_nxt = cnt - 3'd1;
      if (cnt == 3'd1) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      last   <= 1'b1;
      wcount <= 16'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      last   <= last_nxt;
      wcount <= wcount + {15'd0, we};
    end
  end

endmodule
